imem_writer: RTL and testbench
==============================

IMEM_WRITER -- requirements
Module: imem_writer

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory word-address width (1024 words).
REQ-002 Parameter CNT_W, default 11, width of word_count, which allows 0..1024 words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  reset, asynchronous and active-low; Reset=0 clears all state immediately.
REQ-005 start  input  1  one-cycle load request; honoured only in IDLE.
REQ-006 base_addr  input  ADDR_W  first word address written; sampled on an accepted start.
REQ-007 word_count  input  CNT_W  number of 32-bit words to write; sampled on an accepted start.
REQ-008 abort  input  1  synchronous cancel of an active load.
REQ-009 byte_in  input  8  instruction byte stream.
REQ-010 byte_valid  input  1  byte_in holds a valid byte.
REQ-011 byte_ready  output  1  block accepts a byte this cycle; a byte transfers when byte_valid=1 and byte_ready=1.
REQ-012 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-013 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-014 mem_wdata  output  32  assembled instruction word.
REQ-015 busy  output  1  high in all states except IDLE.
REQ-016 done  output  1  one-cycle pulse when a load completes.

Function
REQ-017 The FSM SHALL have four states: IDLE, COLLECT, WRITE and FINISH.
REQ-018 In IDLE, a cycle with start=1 and word_count!=0 SHALL latch base_addr into addr_q and word_count into remain_q, clear the byte counter, and go to COLLECT.
REQ-019 In IDLE, a cycle with start=1 and word_count=0 SHALL go to FINISH with no memory write.
REQ-020 byte_ready SHALL be 1 only in COLLECT.
REQ-021 Each transferred byte SHALL shift into word_q MSB-first: the first byte of a word goes to bits [31:24] and the fourth to bits [7:0].
REQ-022 On the 4th transfer of a word, the block SHALL go to WRITE on the next edge.
REQ-023 In WRITE, mem_we SHALL be 1 for exactly one cycle, with mem_addr=addr_q and mem_wdata=word_q.
REQ-024 On leaving WRITE, remain_q SHALL decrement and addr_q SHALL increment modulo 2^ADDR_W, so 1023 wraps to 0.
REQ-025 On leaving WRITE, the next state SHALL be FINISH if the decremented remain_q is 0, otherwise COLLECT.
REQ-026 In FINISH, done SHALL be 1 for one cycle, and the block SHALL return to IDLE on the next edge.
REQ-027 The latency from the 4th byte transfer to mem_we SHALL be exactly 1 cycle.
REQ-028 The latency from the last mem_we to done SHALL be exactly 1 cycle.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 abort=1 in COLLECT or WRITE SHALL go to IDLE on the next edge, discard the partial word and assert neither mem_we nor done.
REQ-031 If abort and the final WRITE coincide, abort SHALL take priority: mem_we still pulses that cycle, but done is suppressed.
REQ-032 byte_valid=0 stalls in COLLECT SHALL hold all state indefinitely.
REQ-033 mem_we SHALL be 0 outside WRITE.
REQ-034 mem_addr and mem_wdata SHALL always reflect addr_q and word_q.

Reset
REQ-035 Reset=0 SHALL asynchronously force IDLE and clear addr_q, remain_q, the byte counter and word_q to 0.
REQ-036 During and directly after reset, byte_ready, mem_we, busy and done SHALL all be 0.
REQ-037 A reset asserted mid-load SHALL drop any partial word and produce no further write.

Verification
REQ-038 Single word: base_addr=5, word_count=1, bytes 8C,22,00,04 -> one mem_we with addr 5, data 0x8C220004, and done exactly 1 cycle later.
REQ-039 Wrap: base_addr=1023, word_count=2 -> writes to addr 1023 then addr 0, then done.
REQ-040 Zero count: start with word_count=0 -> done 1 cycle later, mem_we never asserted, byte_ready stays 0.
REQ-041 Stall and ignored start: byte_valid toggled randomly and start pulsed mid-load -> data and addresses unchanged, and no restart occurs.
REQ-042 Abort: abort after 2 bytes of word 3 -> returns to IDLE, exactly 2 writes total, no done.
REQ-043 Mid-load reset: Reset=0 during COLLECT -> all outputs 0 immediately; after release, a fresh load of 1 word writes correctly.

Source files
------------

// File: rtl/imem_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_writer_if
//  Purpose  : Bundles the load-control, byte-stream and instruction-memory
//             write signals of the imem_writer block.
//  Modports : master - load controller / byte source / memory side
//             slave  - the imem_writer block itself
//  Signals  : start, base_addr, word_count, abort  (load control)
//             byte_in, byte_valid, byte_ready       (byte stream)
//             mem_we, mem_addr, mem_wdata           (memory write port)
//             busy, done                            (status)
//  Revision : 1.0 - initial release
// ============================================================================
interface imem_writer_if #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              abort;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, word_count, abort, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  start, base_addr, word_count, abort, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/imem_writer.sv
`default_nettype none
// ============================================================================
//  Module   : imem_writer
//  Purpose  : Assembles an MSB-first byte stream into 32-bit instruction words
//             and writes them to consecutive instruction-memory addresses.
//  Ports    : clk   - single clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - imem_writer_if.slave (load control, byte stream,
//                     memory write port, busy/done status)
//  Revision : 1.0 - initial release
// ============================================================================
module imem_writer #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    imem_writer_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remain;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_word;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [CNT_W-1:0]  w_remain_nxt;
    logic [1:0]        w_byte_cnt_nxt;
    logic [31:0]       w_word_nxt;
    logic [CNT_W-1:0]  w_remain_dec;

    assign w_remain_dec = r_remain - CNT_W'(1);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_remain   <= w_remain_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_word     <= w_word_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_remain_nxt   = r_remain;
        w_byte_cnt_nxt = r_byte_cnt;
        w_word_nxt     = r_word;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.word_count != '0) begin
                        w_state_nxt    = S_COLLECT;
                        w_addr_nxt     = bus.base_addr;
                        w_remain_nxt   = bus.word_count;
                        w_byte_cnt_nxt = '0;
                    end else begin
                        // Empty load: report completion without touching memory.
                        w_state_nxt = S_FINISH;
                    end
                end
            end

            S_COLLECT: begin
                if (bus.abort) begin
                    // Any partially assembled word is thrown away.
                    w_state_nxt    = S_IDLE;
                    w_byte_cnt_nxt = '0;
                    w_word_nxt     = '0;
                end else if (bus.byte_valid) begin
                    // Shift left so the first byte ends up in bits [31:24].
                    w_word_nxt     = {r_word[23:0], bus.byte_in};
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state_nxt = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                // Address wraps naturally at 2^ADDR_W.
                w_addr_nxt   = r_addr + ADDR_W'(1);
                w_remain_nxt = w_remain_dec;
                if (bus.abort) begin
                    // The write strobe of this cycle still goes out, but the
                    // load ends here without a done pulse.
                    w_state_nxt = S_IDLE;
                end else if (w_remain_dec == '0) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end

            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs are decoded from registered state only
    // ------------------------------------------------------------------------
    assign bus.byte_ready = (r_state == S_COLLECT);
    assign bus.mem_we     = (r_state == S_WRITE);
    assign bus.done       = (r_state == S_FINISH);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_word;

endmodule
`default_nettype wire

// File: tb/tb_imem_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_writer
//  Purpose  : Directed self-checking bench for imem_writer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_writer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_writer_if #(.ADDR_W(10), .CNT_W(11)) bus ();

    imem_writer #(.ADDR_W(10), .CNT_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int xfer_cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: logs memory writes, done pulses and byte_ready cycles.
    int          wr_n    = 0;
    int          done_n  = 0;
    int          ready_n = 0;
    int          done_cyc = 0;
    logic [9:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    int          wr_cyc  [0:63];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] <= bus.mem_addr;
                wr_data[wr_n] <= bus.mem_wdata;
                wr_cyc[wr_n]  <= cyc;
            end
            wr_n <= wr_n + 1;
        end
        if (bus.done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (bus.byte_ready) ready_n <= ready_n + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(input logic [9:0] base, input logic [10:0] cnt);
        bus.base_addr  = base;
        bus.word_count = cnt;
        bus.start      = 1'b1;
        start_cyc      = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        bit got;
        k   = 0;
        got = 1'b0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!got && k < 50) begin
            @(negedge clk);
            if (bus.byte_ready) begin
                got      = 1'b1;
                xfer_cyc = cyc;
            end
            k++;
        end
        check_val("byte_accept", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    // Bounded wait for done_n to move past d0.
    task automatic wait_done(input int d0, input int max_cyc);
        int k;
        k = 0;
        while (done_n == d0 && k < max_cyc) begin
            @(negedge clk);
            #1;
            k++;
        end
    endtask

    int w0, d0, r0;
    logic [31:0] sw [0:2];

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.abort      = 1'b0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        check_val("rst_busy",  32'(bus.busy),       32'd0);
        check_val("rst_ready", 32'(bus.byte_ready), 32'd0);
        check_val("rst_we",    32'(bus.mem_we),     32'd0);
        check_val("rst_done",  32'(bus.done),       32'd0);
        check_val("rst_addr",  32'(bus.mem_addr),   32'd0);
        check_val("rst_wdata", bus.mem_wdata,        32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", 32'(bus.busy), 32'd0);
        check_val("post_rst_done", 32'(bus.done), 32'd0);
        tick(1);

        // ---------------- single word ----------------
        w0 = wr_n; d0 = done_n;
        start_load(10'd5, 11'd1);
        check_val("sw_busy", 32'(bus.busy), 32'd1);
        send_word(32'h8C22_0004);
        wait_done(d0, 20);
        tick(3);
        check_val("sw_nwr",   32'(wr_n - w0),    32'd1);
        check_val("sw_addr",  32'(wr_addr[w0]),  32'd5);
        check_val("sw_data",  wr_data[w0],       32'h8C22_0004);
        check_val("sw_we_lat", 32'(wr_cyc[w0] - xfer_cyc), 32'd1);
        check_val("sw_ndone", 32'(done_n - d0),  32'd1);
        check_val("sw_done_lat", 32'(done_cyc - wr_cyc[w0]), 32'd1);
        check_val("sw_idle",  32'(bus.busy),     32'd0);

        // ---------------- address wrap ----------------
        w0 = wr_n; d0 = done_n;
        start_load(10'd1023, 11'd2);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        wait_done(d0, 20);
        tick(3);
        check_val("wrap_nwr",   32'(wr_n - w0),       32'd2);
        check_val("wrap_addr0", 32'(wr_addr[w0]),     32'd1023);
        check_val("wrap_data0", wr_data[w0],          32'h1122_3344);
        check_val("wrap_addr1", 32'(wr_addr[w0 + 1]), 32'd0);
        check_val("wrap_data1", wr_data[w0 + 1],      32'h5566_7788);
        check_val("wrap_ndone", 32'(done_n - d0),     32'd1);
        check_val("wrap_done_lat", 32'(done_cyc - wr_cyc[w0 + 1]), 32'd1);

        // ---------------- zero count ----------------
        w0 = wr_n; d0 = done_n; r0 = ready_n;
        start_load(10'd33, 11'd0);
        wait_done(d0, 10);
        tick(3);
        check_val("zero_ndone", 32'(done_n - d0),         32'd1);
        check_val("zero_lat",   32'(done_cyc - start_cyc), 32'd1);
        check_val("zero_nwr",   32'(wr_n - w0),           32'd0);
        check_val("zero_ready", 32'(ready_n - r0),        32'd0);

        // ---------------- stalls + ignored start ----------------
        sw[0] = 32'hA1B2_C3D4;
        sw[1] = 32'h0BAD_F00D;
        sw[2] = 32'h1357_9BDF;
        w0 = wr_n; d0 = done_n;
        start_load(10'd100, 11'd3);
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                int gaps;
                gaps = int'($urandom_range(0, 3));
                if (b == 1) gaps = gaps + 1;
                for (int g = 0; g < gaps; g++) begin
                    if (g == 0 && b == 1) begin
                        bus.start      = 1'b1;
                        bus.base_addr  = 10'd7;
                        bus.word_count = 11'd1;
                    end
                    @(posedge clk);
                    #1;
                    bus.start = 1'b0;
                end
                send_byte(sw[w][31 - 8*b -: 8]);
            end
        end
        wait_done(d0, 20);
        tick(5);
        check_val("stall_nwr", 32'(wr_n - w0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val("stall_addr", 32'(wr_addr[w0 + i]), 32'(100 + i));
            check_val("stall_data", wr_data[w0 + i],      sw[i]);
        end
        check_val("stall_ndone", 32'(done_n - d0), 32'd1);
        check_val("stall_idle",  32'(bus.busy),    32'd0);

        // ---------------- abort in word 3 ----------------
        w0 = wr_n; d0 = done_n;
        start_load(10'd20, 11'd4);
        send_word(32'hCAFE_0001);
        send_word(32'hCAFE_0002);
        send_byte(8'hEE);
        send_byte(8'hFF);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        check_val("abort_busy",  32'(bus.busy),       32'd0);
        check_val("abort_ready", 32'(bus.byte_ready), 32'd0);
        tick(10);
        check_val("abort_nwr",   32'(wr_n - w0),      32'd2);
        check_val("abort_ndone", 32'(done_n - d0),    32'd0);

        // ---------------- abort coinciding with final write ----------------
        w0 = wr_n; d0 = done_n;
        start_load(10'd40, 11'd1);
        send_word(32'h0F0F_F0F0);
        bus.abort = 1'b1;      // this cycle is the final WRITE
        tick(1);
        bus.abort = 1'b0;
        tick(5);
        check_val("abwr_nwr",   32'(wr_n - w0),     32'd1);
        check_val("abwr_data",  wr_data[w0],        32'h0F0F_F0F0);
        check_val("abwr_ndone", 32'(done_n - d0),   32'd0);

        // ---------------- mid-load reset ----------------
        start_load(10'd50, 11'd2);
        send_byte(8'h12);
        send_byte(8'h34);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mrst_busy",  32'(bus.busy),       32'd0);
        check_val("mrst_ready", 32'(bus.byte_ready), 32'd0);
        check_val("mrst_we",    32'(bus.mem_we),     32'd0);
        check_val("mrst_addr",  32'(bus.mem_addr),   32'd0);
        check_val("mrst_wdata", bus.mem_wdata,        32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        w0 = wr_n; d0 = done_n;
        start_load(10'd9, 11'd1);
        send_word(32'hDEAD_BEEF);
        wait_done(d0, 20);
        tick(3);
        check_val("mrst_nwr",   32'(wr_n - w0),    32'd1);
        check_val("mrst_addr2", 32'(wr_addr[w0]),  32'd9);
        check_val("mrst_data2", wr_data[w0],       32'hDEAD_BEEF);
        check_val("mrst_ndone", 32'(done_n - d0),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
